// File: rtl/writeback.sv
// writeback: final RV32I pipeline stage.
// Latches the memory-read stage outputs (M_*) into the W stage and commits
// the W-stage destination value into the 32-entry register file when the
// stage advances. Two combinational read ports serve decode and bypass the
// not-yet-committed W-stage value. INSTRET counts committed instructions.
//
// Ports:
//   CLK, RST             clock, asynchronous active-high reset
//   STALL                hold W stage; no latch, no commit, no count
//   M_PC/M_INST/M_VALID/M_REG_D/M_REG_D_V   incoming instruction
//   RS1_ADDR/RS2_ADDR    read indices, RS1_DATA/RS2_DATA read data
//   W_PC/W_INST/W_VALID/W_REG_D/W_REG_D_V   W-stage contents
//   INSTRET              retired-instruction counter (wraps)
module writeback #(
    parameter int unsigned INSTRET_W = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 STALL,
    input  logic [31:0]          M_PC,
    input  logic [31:0]          M_INST,
    input  logic                 M_VALID,
    input  logic [4:0]           M_REG_D,
    input  logic [31:0]          M_REG_D_V,
    input  logic [4:0]           RS1_ADDR,
    input  logic [4:0]           RS2_ADDR,
    output logic [31:0]          RS1_DATA,
    output logic [31:0]          RS2_DATA,
    output logic [31:0]          W_PC,
    output logic [31:0]          W_INST,
    output logic                 W_VALID,
    output logic [4:0]           W_REG_D,
    output logic [31:0]          W_REG_D_V,
    output logic [INSTRET_W-1:0] INSTRET
);

    logic [31:0]          w_pc_q,      w_pc_d;
    logic [31:0]          w_inst_q,    w_inst_d;
    logic                 w_valid_q,   w_valid_d;
    logic [4:0]           w_reg_d_q,   w_reg_d_d;
    logic [31:0]          w_reg_d_v_q, w_reg_d_v_d;
    logic [INSTRET_W-1:0] instret_q,   instret_d;
    logic [31:0]          regs_q [32];
    logic [31:0]          regs_d [32];

    // Next-state: the instruction currently in W commits on the same edge
    // that the new one is latched, so both use the pre-edge W contents.
    always_comb begin
        w_pc_d      = w_pc_q;
        w_inst_d    = w_inst_q;
        w_valid_d   = w_valid_q;
        w_reg_d_d   = w_reg_d_q;
        w_reg_d_v_d = w_reg_d_v_q;
        instret_d   = instret_q;
        regs_d      = regs_q;
        if (!STALL) begin
            if (w_valid_q) begin
                instret_d = instret_q + INSTRET_W'(1);
                if (w_reg_d_q != 5'd0) begin
                    regs_d[w_reg_d_q] = w_reg_d_v_q;
                end
            end
            w_pc_d      = M_PC;
            w_inst_d    = M_INST;
            w_valid_d   = M_VALID;
            w_reg_d_d   = M_REG_D;
            w_reg_d_v_d = M_REG_D_V;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_pc_q      <= '0;
            w_inst_q    <= '0;
            w_valid_q   <= 1'b0;
            w_reg_d_q   <= '0;
            w_reg_d_v_q <= '0;
            instret_q   <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            w_pc_q      <= w_pc_d;
            w_inst_q    <= w_inst_d;
            w_valid_q   <= w_valid_d;
            w_reg_d_q   <= w_reg_d_d;
            w_reg_d_v_q <= w_reg_d_v_d;
            instret_q   <= instret_d;
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports: x0 is hardwired zero; a valid W-stage write to the same
    // index takes priority over the register file (also while stalled).
    always_comb begin
        if (RS1_ADDR == 5'd0) begin
            RS1_DATA = '0;
        end else if (w_valid_q && (w_reg_d_q == RS1_ADDR)) begin
            RS1_DATA = w_reg_d_v_q;
        end else begin
            RS1_DATA = regs_q[RS1_ADDR];
        end

        if (RS2_ADDR == 5'd0) begin
            RS2_DATA = '0;
        end else if (w_valid_q && (w_reg_d_q == RS2_ADDR)) begin
            RS2_DATA = w_reg_d_v_q;
        end else begin
            RS2_DATA = regs_q[RS2_ADDR];
        end
    end

    assign W_PC      = w_pc_q;
    assign W_INST    = w_inst_q;
    assign W_VALID   = w_valid_q;
    assign W_REG_D   = w_reg_d_q;
    assign W_REG_D_V = w_reg_d_v_q;
    assign INSTRET   = instret_q;

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;

    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic [31:0]   m_pc = '0;
    logic [31:0]   m_inst = '0;
    logic          m_valid = 1'b0;
    logic [4:0]    m_reg_d = '0;
    logic [31:0]   m_reg_d_v = '0;
    logic [4:0]    rs1_addr = '0;
    logic [4:0]    rs2_addr = '0;
    logic [31:0]   rs1_data, rs2_data;
    logic [31:0]   w_pc, w_inst, w_reg_d_v;
    logic          w_valid;
    logic [4:0]    w_reg_d;
    logic [IW-1:0] instret;

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    writeback #(.INSTRET_W(IW)) dut (
        .CLK(clk), .RST(rst), .STALL(stall),
        .M_PC(m_pc), .M_INST(m_inst), .M_VALID(m_valid),
        .M_REG_D(m_reg_d), .M_REG_D_V(m_reg_d_v),
        .RS1_ADDR(rs1_addr), .RS2_ADDR(rs2_addr),
        .RS1_DATA(rs1_data), .RS2_DATA(rs2_data),
        .W_PC(w_pc), .W_INST(w_inst), .W_VALID(w_valid),
        .W_REG_D(w_reg_d), .W_REG_D_V(w_reg_d_v), .INSTRET(instret)
    );

    always #5 clk = ~clk;

    // Reference model: one pipeline slot plus architectural state.
    typedef struct {
        bit          valid;
        bit [31:0]   pc;
        bit [31:0]   inst;
        int unsigned rd;
        bit [31:0]   val;
    } slot_t;

    slot_t       ws;
    bit [31:0]   arch [32];
    int unsigned retired;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ws = '{valid: 0, pc: 0, inst: 0, rd: 0, val: 0};
            foreach (arch[i]) arch[i] = 0;
            retired = 0;
        end else if (!stall) begin
            if (ws.valid) begin
                retired = (retired + 1) % (1 << IW);
                if (ws.rd != 0) arch[ws.rd] = ws.val;
            end
            ws = '{valid: m_valid, pc: m_pc, inst: m_inst,
                   rd: int'(m_reg_d), val: m_reg_d_v};
        end
    end

    function automatic bit [31:0] model_read(input int unsigned a);
        if (a == 0) return 0;
        if (ws.valid && ws.rd == a) return ws.val;
        return arch[a];
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!done) begin
            cmp("w_valid", {31'd0, w_valid}, {31'd0, ws.valid});
            cmp("w_pc", w_pc, ws.pc);
            cmp("w_inst", w_inst, ws.inst);
            cmp("w_reg_d", {27'd0, w_reg_d}, ws.rd);
            cmp("w_reg_d_v", w_reg_d_v, ws.val);
            cmp("instret", {28'd0, instret}, retired);
            cmp("rs1_data", rs1_data, model_read(int'(rs1_addr)));
            cmp("rs2_data", rs2_data, model_read(int'(rs2_addr)));
        end
    end

    // Drive inputs 2 time units after a rising edge.
    task automatic step(input bit st, input bit v, input logic [4:0] rd,
                        input logic [31:0] val, input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk);
        #2;
        stall     = st;
        m_valid   = v;
        m_reg_d   = rd;
        m_reg_d_v = val;
        m_pc      = m_pc + 32'd4;
        m_inst    = $urandom;
        rs1_addr  = a1;
        rs2_addr  = a2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #4;
        cmp("lit_reset_instret", {28'd0, instret}, 32'd0);

        // Single write to x5
        step(0, 1, 5, 32'hDEADBEEF, 5, 0);
        step(0, 0, 0, 0, 5, 0);
        #4;
        cmp("lit_x5_bypass", rs1_data, 32'hDEADBEEF);
        cmp("lit_x5_bypass_cnt", {28'd0, instret}, 32'd0);
        step(0, 0, 0, 0, 5, 0);
        #4;
        cmp("lit_x5_reg", rs1_data, 32'hDEADBEEF);
        cmp("lit_x5_cnt", {28'd0, instret}, 32'd1);
        cmp("lit_x5_wvalid", {31'd0, w_valid}, 32'd0);

        // x0 protection
        step(0, 1, 0, 32'h12345678, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        #4;
        cmp("lit_x0_bypass", rs1_data, 32'd0);
        step(0, 0, 0, 0, 0, 0);
        #4;
        cmp("lit_x0_commit", rs1_data, 32'd0);
        cmp("lit_x0_cnt", {28'd0, instret}, 32'd2);

        // Stall hold on x7
        step(0, 1, 7, 32'hA5A5A5A5, 0, 7);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 8, 32'h11111111, 0, 7);
            #4;
            cmp("lit_stall_rs2", rs2_data, 32'hA5A5A5A5);
            cmp("lit_stall_wrd", {27'd0, w_reg_d}, 32'd7);
            cmp("lit_stall_cnt", {28'd0, instret}, 32'd2);
        end
        step(0, 0, 0, 0, 0, 7);
        step(0, 0, 0, 0, 0, 7);
        #4;
        cmp("lit_stall_rel_cnt", {28'd0, instret}, 32'd3);
        cmp("lit_stall_rel_reg", rs2_data, 32'hA5A5A5A5);
        step(0, 0, 0, 0, 8, 7);
        #4;
        cmp("lit_stall_once", {28'd0, instret}, 32'd3);
        cmp("lit_stall_no_x8", rs1_data, 32'd0);

        // Back-to-back x3
        step(0, 1, 3, 32'd1, 3, 0);
        step(0, 1, 3, 32'd2, 3, 0);
        #4;
        cmp("lit_b2b_1", rs1_data, 32'd1);
        step(0, 0, 0, 0, 3, 0);
        #4;
        cmp("lit_b2b_2", rs1_data, 32'd2);
        step(0, 0, 0, 0, 3, 0);
        #4;
        cmp("lit_b2b_3", rs1_data, 32'd2);
        cmp("lit_b2b_cnt", {28'd0, instret}, 32'd5);

        // Invalid bubble to x9
        step(0, 0, 9, 32'hFFFF0000, 9, 9);
        step(0, 0, 0, 0, 9, 9);
        #4;
        cmp("lit_bubble_bypass", rs1_data, 32'd0);
        step(0, 0, 0, 0, 9, 9);
        #4;
        cmp("lit_bubble_reg", rs2_data, 32'd0);
        cmp("lit_bubble_cnt", {28'd0, instret}, 32'd5);

        // Mid-cycle asynchronous reset with a valid instruction in W
        step(0, 1, 4, 32'hCAFEF00D, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        #5;
        rst = 1'b1;
        #1;
        cmp("lit_arst_wvalid", {31'd0, w_valid}, 32'd0);
        cmp("lit_arst_cnt", {28'd0, instret}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #0.1;
            cmp("lit_arst_rs1", rs1_data, 32'd0);
            cmp("lit_arst_rs2", rs2_data, 32'd0);
        end
        step(0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Counter wrap: 16 commits from zero
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 10, 32'(i), 10, 0);
        end
        step(0, 0, 0, 0, 10, 0);
        #4;
        cmp("lit_wrap_15", {28'd0, instret}, 32'd15);
        step(0, 0, 0, 0, 10, 0);
        #4;
        cmp("lit_wrap_0", {28'd0, instret}, 32'd0);
        cmp("lit_wrap_x10", rs1_data, 32'd15);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 31)),
                 $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 199) == 0) begin
                #4;
                rst = 1'b1;
                #2;
                rst = 1'b0;
            end
        end
        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback.md
Name: writeback

Overview:
- Final RV32I pipeline stage, directly downstream of the memory-read stage; consumes its M_* outputs.
- Registers the incoming instruction into the W stage and commits the destination value into the architectural register file (x0..x31).
- Serves two combinational register read ports with W-stage bypass to the decode stage.
- Maintains a retired-instruction counter.

Parameters:
INSTRET_W, 64, width of the retired-instruction counter (wraps modulo 2^INSTRET_W)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  reset, asynchronous, active-high
STALL  input  1  pipeline stall; W stage holds and commits nothing while high
M_PC  input  32  PC of instruction leaving memory-read stage
M_INST  input  32  instruction word
M_VALID  input  1  instruction valid
M_REG_D  input  5  destination register index
M_REG_D_V  input  32  destination register value
RS1_ADDR  input  5  read port 1 index (from decode)
RS2_ADDR  input  5  read port 2 index (from decode)
RS1_DATA  output  32  read port 1 data
RS2_DATA  output  32  read port 2 data
W_PC  output  32  PC held in W stage
W_INST  output  32  instruction held in W stage
W_VALID  output  1  W stage holds a valid instruction
W_REG_D  output  5  destination index in W stage
W_REG_D_V  output  32  destination value in W stage
INSTRET  output  INSTRET_W  count of committed instructions

Behaviour:
- Reset (async, RST=1): W_PC=0, W_INST=0, W_VALID=0, W_REG_D=0, W_REG_D_V=0, INSTRET=0, all 32 registers = 0. Takes effect immediately, regardless of CLK; any commit in flight is discarded.
- Stage latch: on rising edge with STALL=0, W_* <= M_* (all five fields). With STALL=1, W_* hold.
- Commit event: rising edge where STALL=0 and W_VALID=1 (the instruction currently in W leaves the stage).
  - On commit, if W_REG_D != 0: reg[W_REG_D] <= W_REG_D_V.
  - On commit: INSTRET <= INSTRET + 1. Wraps to 0 from all-ones.
  - W_REG_D=0 still counts as retired; x0 is never written.
- Stall: no commit, no counter increment and no latch while STALL=1. An instruction held for N stall cycles is committed and counted exactly once.
- Invalid instruction (W_VALID=0): no register write and no count, even if W_REG_D/W_REG_D_V are nonzero.
- Read ports (combinational, zero latency). For each port p:
  - addr=0 -> 0.
  - else if W_VALID=1 and W_REG_D=addr -> W_REG_D_V (bypass of the not-yet-committed value). Applies during stall too.
  - else -> reg[addr].
  - Bypass priority is over the register file contents.
- Both ports may read the same index simultaneously; both return identical data.
- Latency: value entering on M_* is visible via bypass 1 cycle later (on W_*). It is in the register file after the following non-stalled edge.
- Back-to-back writes to the same register: bypass always reflects the younger (W-stage) value. The register file holds the older value until the next commit overwrites it.
- Register file is 32x32 flops with async reset; no read-during-write hazard beyond the bypass rule above.

Test Plan:
- Reset then idle: assert RST mid-cycle with W_VALID=1 and stale registers -> W_VALID=0, INSTRET=0, RS1_DATA=RS2_DATA=0 for all addresses, immediately without a clock edge.
- Single write: M_VALID=1, M_REG_D=5, M_REG_D_V=0xDEADBEEF for one cycle, RS1_ADDR=5.
  - Next cycle: RS1_DATA=0xDEADBEEF via bypass.
  - After the following edge: value in reg[5], still 0xDEADBEEF, INSTRET=1.
- x0 protection: commit M_REG_D=0, value 0x12345678 -> RS1_ADDR=0 reads 0 in both the bypass and post-commit cycles; INSTRET increments by 1.
- Stall hold: instruction to x7 (value 0xA5A5A5A5) in W, STALL=1 for 3 cycles -> W_* unchanged, RS2_ADDR=7 returns 0xA5A5A5A5 throughout, INSTRET unchanged. After release: INSTRET +1 exactly once.
- Back-to-back same register: x3 <= 1 then x3 <= 2 on consecutive cycles -> RS1_ADDR=3 reads 1, then 2, then 2; INSTRET +2.
- Invalid bubble plus counter wrap (INSTRET_W=4):
  - M_VALID=0 with M_REG_D=9 -> reg[9] stays 0, no count.
  - 16 valid commits -> INSTRET returns to 0.
